// File: rtl/addac_seq.sv
// Command sequencer for the 4-bit add/accumulate stage: FIFO-buffered commands,
// fixed setup/strobe/hold drive of the accumulator, and a valid/ready result port.
module addac_seq #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] acc_a,
  output logic             acc_sel0,
  output logic             acc_sel1,
  output logic             acc_iclk,
  input  logic [WIDTH-1:0] acc_s,
  input  logic             acc_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_cout,
  output logic [CNT_W-1:0] op_count,
  output logic             busy
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FILL_W = PTR_W + 1;

  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] data;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    RESULT = 3'd4
  } state_t;

  state_t state, state_nxt;

  cmd_t              mem [DEPTH];
  cmd_t              rd_cmd;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FILL_W-1:0] fill;
  logic              full, empty, push;
  logic              pop, sample, res_fire, iclk_nxt;

  assign full      = (fill == FILL_W'(DEPTH));
  assign empty     = (fill == '0);
  assign push      = cmd_valid && !full;
  assign cmd_ready = !full;
  assign rd_cmd    = mem[rd_ptr];
  assign busy      = (state != IDLE) || !empty;

  // Command storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: cmd_op, data: cmd_data};
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fill <= fill + FILL_W'(1);
        2'b01:   fill <= fill - FILL_W'(1);
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = SETUP;
      SETUP:   state_nxt = STROBE;
      STROBE:  state_nxt = HOLD;
      HOLD:    state_nxt = RESULT;
      RESULT:  if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop      = 1'b0;
    sample   = 1'b0;
    res_fire = 1'b0;
    iclk_nxt = 1'b0;
    case (state)
      IDLE:    pop      = !empty;
      SETUP:   iclk_nxt = 1'b1;
      HOLD:    sample   = 1'b1;
      RESULT:  res_fire = res_ready;
      default: ;
    endcase
  end

  // Strobe is registered so it is high for exactly the STROBE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_a     <= '0;
      acc_sel0  <= 1'b0;
      acc_sel1  <= 1'b0;
      acc_iclk  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_cout  <= 1'b0;
      op_count  <= '0;
    end else begin
      acc_iclk <= iclk_nxt;
      if (pop) begin
        acc_a    <= rd_cmd.data;
        acc_sel0 <= rd_cmd.op[0];
        acc_sel1 <= rd_cmd.op[1];
      end
      if (sample) begin
        res_data  <= acc_s;
        res_cout  <= acc_cout;
        res_valid <= 1'b1;
      end else if (res_fire) begin
        res_valid <= 1'b0;
      end
      if (res_fire) op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_addac_seq.sv
// Bench for addac_seq: a strobe-latched accumulator stub plus a queue-based
// reference of expected results, driven with randomized commands and readiness.
module tb_addac_seq;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] acc_a;
  logic             acc_sel0;
  logic             acc_sel1;
  logic             acc_iclk;
  logic [WIDTH-1:0] acc_s;
  logic             acc_cout;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_cout;
  logic [CNT_W-1:0] op_count;
  logic             busy;

  int errors;
  int checks;
  int exp_cnt;
  int iclk_rise;
  int iclk_hi;

  logic             ovr_en;
  logic [WIDTH-1:0] ovr_s;
  logic             ovr_c;
  logic [4:0]       stub_q;

  addac_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .acc_a(acc_a), .acc_sel0(acc_sel0), .acc_sel1(acc_sel1), .acc_iclk(acc_iclk),
    .acc_s(acc_s), .acc_cout(acc_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_cout(res_cout),
    .op_count(op_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub accumulator: result {cout,sum} of operand plus 7*op, latched on the strobe.
  function automatic logic [4:0] acc_model(input logic [3:0] a, input logic [1:0] op);
    int v;
    v = int'(a) + 7 * int'(op);
    return 5'(v);
  endfunction

  always @(posedge acc_iclk or posedge rst) begin
    if (rst) stub_q <= '0;
    else     stub_q <= acc_model(acc_a, {acc_sel1, acc_sel0});
  end

  assign acc_s    = ovr_en ? ovr_s : stub_q[3:0];
  assign acc_cout = ovr_en ? ovr_c : stub_q[4];

  always @(posedge acc_iclk) iclk_rise <= iclk_rise + 1;
  always @(posedge clk) if (acc_iclk === 1'b1) iclk_hi <= iclk_hi + 1;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    ovr_en    = 1'b0;
    rst       = 1'b1;
    cyc(2);
    rst       = 1'b0;
    exp_cnt   = 0;
  endtask

  task automatic test_reset();
    int bad;
    int base;
    cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; res_ready = 1'b0;
    ovr_en = 1'b0; ovr_s = '0; ovr_c = 1'b0;
    rst = 1'b1;
    cyc(3);
    checks++;
    if ({acc_a, acc_sel0, acc_sel1, acc_iclk, res_valid, res_data, res_cout, op_count, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got a=%h s0=%b s1=%b iclk=%b rv=%b rd=%h rc=%b cnt=%0d busy=%b, expected all 0",
               acc_a, acc_sel0, acc_sel1, acc_iclk, res_valid, res_data, res_cout, op_count, busy);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
    end
    rst = 1'b0;
    exp_cnt = 0;
    base = iclk_rise;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (acc_iclk !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0 || cmd_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL idle_quiet: got %0d bad cycles expected 0", bad);
    end
    checks++;
    if (iclk_rise - base != 0) begin
      errors++; $display("FAIL idle_no_strobe: got %0d strobes expected 0", iclk_rise - base);
    end
  endtask

  task automatic test_single();
    int base_r;
    int base_h;
    ovr_en = 1'b1; ovr_s = 4'h7; ovr_c = 1'b1; res_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 4'hA;
    base_r = iclk_rise; base_h = iclk_hi;
    cyc(1);
    cmd_valid = 1'b0;
    cyc(1);
    checks++;
    if ({acc_a, acc_sel1, acc_sel0, acc_iclk} !== {4'hA, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL single_operand: got a=%h s1=%b s0=%b iclk=%b expected a=a s1=0 s0=1 iclk=0",
                         acc_a, acc_sel1, acc_sel0, acc_iclk);
    end
    cyc(1);
    checks++;
    if (acc_iclk !== 1'b1) begin
      errors++; $display("FAIL single_strobe: got %b expected 1", acc_iclk);
    end
    cyc(1);
    checks++;
    if ({acc_iclk, res_valid} !== 2'b00) begin
      errors++; $display("FAIL single_hold: got iclk=%b rv=%b expected 0 0", acc_iclk, res_valid);
    end
    cyc(1);
    checks++;
    if ({res_valid, res_data, res_cout} !== {1'b1, 4'h7, 1'b1}) begin
      errors++; $display("FAIL single_result: got rv=%b rd=%h rc=%b expected 1 7 1", res_valid, res_data, res_cout);
    end
    cyc(1);
    exp_cnt++;
    checks++;
    if (res_valid !== 1'b0 || op_count !== CNT_W'(exp_cnt)) begin
      errors++; $display("FAIL single_count: got rv=%b cnt=%0d expected 0 %0d", res_valid, op_count, exp_cnt);
    end
    checks++;
    if (iclk_rise - base_r != 1 || iclk_hi - base_h != 1) begin
      errors++; $display("FAIL single_strobe_width: got rises=%0d hi=%0d expected 1 1",
                         iclk_rise - base_r, iclk_hi - base_h);
    end
    ovr_en = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [4:0] q[$];
    logic [4:0] e;
    int stalls;
    int got;
    int last;
    int bad_gap;
    res_ready = 1'b0;
    stalls = 0;
    for (int i = 1; i <= 5; i++) begin
      cmd_valid = 1'b1;
      cmd_data  = 4'(i);
      cmd_op    = 2'($urandom_range(0, 3));
      if (cmd_ready !== 1'b1) stalls++;
      q.push_back(acc_model(cmd_data, cmd_op));
      cyc(1);
    end
    cmd_valid = 1'b0;
    checks++;
    if (stalls != 0) begin
      errors++; $display("FAIL bp_accept: got %0d refused pushes expected 0", stalls);
    end
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL bp_full: got ready=%b busy=%b expected 0 1", cmd_ready, busy);
    end
    cyc(6);
    checks++;
    if (res_valid !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL bp_hold_full: got rv=%b ready=%b expected 1 0", res_valid, cmd_ready);
    end
    res_ready = 1'b1;
    got = 0; last = 0; bad_gap = 0;
    for (int k = 0; k < 100 && got < 5; k++) begin
      if (res_valid === 1'b1) begin
        e = q.pop_front();
        checks++;
        if ({res_cout, res_data} !== e) begin
          errors++; $display("FAIL bp_order[%0d]: got %h expected %h", got, {res_cout, res_data}, e);
        end
        if (got > 0 && k - last != 5) bad_gap++;
        last = k;
        got++;
        exp_cnt++;
      end
      cyc(1);
    end
    checks++;
    if (got != 5 || bad_gap != 0) begin
      errors++; $display("FAIL bp_drain: got %0d results %0d bad gaps expected 5 0", got, bad_gap);
    end
    checks++;
    if (op_count !== CNT_W'(exp_cnt) || busy !== 1'b0) begin
      errors++; $display("FAIL bp_count: got cnt=%0d busy=%b expected %0d 0", op_count, busy, exp_cnt);
    end
    res_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic [4:0] e;
    int n;
    res_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_data  = 4'($urandom);
    cmd_op    = 2'($urandom);
    e = acc_model(cmd_data, cmd_op);
    cyc(1);
    cmd_valid = 1'b0;
    n = 0;
    while (res_valid !== 1'b1 && n < 20) begin
      cyc(1);
      n++;
    end
    checks++;
    if (res_valid !== 1'b1) begin
      errors++; $display("FAIL stall_timeout: got rv=%b expected 1 within 20 cycles", res_valid);
    end
    ovr_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ovr_s = 4'($urandom);
      ovr_c = 1'($urandom);
      cyc(1);
      checks++;
      if (res_valid !== 1'b1 || {res_cout, res_data} !== e || op_count !== CNT_W'(exp_cnt)) begin
        errors++; $display("FAIL stall_hold[%0d]: got rv=%b res=%h cnt=%0d expected 1 %h %0d",
                           i, res_valid, {res_cout, res_data}, op_count, e, exp_cnt);
      end
    end
    res_ready = 1'b1;
    cyc(1);
    exp_cnt++;
    checks++;
    if (res_valid !== 1'b0 || op_count !== CNT_W'(exp_cnt)) begin
      errors++; $display("FAIL stall_release: got rv=%b cnt=%0d expected 0 %0d", res_valid, op_count, exp_cnt);
    end
    ovr_en = 1'b0;
    res_ready = 1'b0;
  endtask

  task automatic test_traffic(input int n, input int pv, input int pr);
    logic [4:0] q[$];
    logic [4:0] e;
    int sent;
    int rcvd;
    int base_r;
    int base_h;
    sent = 0; rcvd = 0;
    base_r = iclk_rise; base_h = iclk_hi;
    for (int k = 0; k < n * 20 + 50 && rcvd < n; k++) begin
      cmd_valid = (sent < n) && ($urandom_range(0, 99) < pv);
      cmd_data  = 4'($urandom);
      cmd_op    = 2'($urandom);
      res_ready = ($urandom_range(0, 99) < pr);
      if (cmd_valid && cmd_ready === 1'b1) begin
        q.push_back(acc_model(cmd_data, cmd_op));
        sent++;
      end
      if (res_valid === 1'b1 && res_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL traffic_spurious: got result %h expected none", {res_cout, res_data});
        end else begin
          e = q.pop_front();
          if ({res_cout, res_data} !== e) begin
            errors++; $display("FAIL traffic_data[%0d]: got %h expected %h", rcvd, {res_cout, res_data}, e);
          end
        end
        rcvd++;
        exp_cnt++;
      end
      cyc(1);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    checks++;
    if (rcvd != n) begin
      errors++; $display("FAIL traffic_timeout: got %0d results expected %0d", rcvd, n);
    end
    checks++;
    if (op_count !== CNT_W'(exp_cnt) || busy !== 1'b0) begin
      errors++; $display("FAIL traffic_count: got cnt=%0d busy=%b expected %0d 0",
                         op_count, busy, CNT_W'(exp_cnt));
    end
    checks++;
    if (iclk_rise - base_r != n || iclk_hi - base_h != n) begin
      errors++; $display("FAIL traffic_strobes: got rises=%0d hi=%0d expected %0d %0d",
                         iclk_rise - base_r, iclk_hi - base_h, n, n);
    end
  endtask

  task automatic test_reset_midop();
    int n;
    int bad;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1;
      cmd_data  = 4'($urandom);
      cmd_op    = 2'($urandom);
      cyc(1);
    end
    cmd_valid = 1'b0;
    n = 0;
    while (acc_iclk !== 1'b1 && n < 20) begin
      cyc(1);
      n++;
    end
    checks++;
    if (acc_iclk !== 1'b1) begin
      errors++; $display("FAIL midop_strobe_seen: got %b expected 1 within 20 cycles", acc_iclk);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({acc_iclk, res_valid, busy, cmd_ready} !== 4'b0001) begin
      errors++; $display("FAIL midop_async: got iclk=%b rv=%b busy=%b ready=%b expected 0 0 0 1",
                         acc_iclk, res_valid, busy, cmd_ready);
    end
    cyc(2);
    rst = 1'b0;
    exp_cnt = 0;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      cyc(1);
      if (res_valid !== 1'b0 || acc_iclk !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL midop_no_result: got %0d active cycles expected 0", bad);
    end
    test_traffic(12, 70, 60);
  endtask

  task automatic test_wrap();
    apply_reset();
    test_traffic(256, 100, 100);
    checks++;
    if (op_count !== 8'd0) begin
      errors++; $display("FAIL wrap_zero: got %0d expected 0", op_count);
    end
    test_traffic(1, 100, 100);
    checks++;
    if (op_count !== 8'd1) begin
      errors++; $display("FAIL wrap_one: got %0d expected 1", op_count);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    errors = 0;
    checks = 0;
    exp_cnt = 0;
    test_reset();
    test_single();
    test_backpressure();
    test_stall();
    test_traffic(40, 60, 50);
    test_reset_midop();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/addac_seq.md
Name: addac_seq

Overview:
Command sequencer that sits directly upstream of the 4-bit add/accumulate stage. It buffers operand/opcode commands in a small FIFO and drives the accumulator's operand, select lines and clock strobe with a fixed setup/strobe/hold schedule. After each operation it samples the accumulator's sum and carry and returns them on a valid/ready result port, so the rest of the design never toggles the accumulator directly.

Parameters:
WIDTH, 4, operand and result width (matches accumulator datapath)
DEPTH, 4, command FIFO entries (power of two, >= 2)
CNT_W, 8, width of the completed-operation counter

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept a command
cmd_op  in  2  {sel1, sel0} code forwarded to accumulator
cmd_data  in  WIDTH  operand forwarded to accumulator
acc_a  out  WIDTH  accumulator operand
acc_sel0  out  1  accumulator select 0
acc_sel1  out  1  accumulator select 1
acc_iclk  out  1  accumulator clock strobe (registered)
acc_s  in  WIDTH  accumulator sum
acc_cout  in  1  accumulator carry out
res_valid  out  1  result available
res_ready  in  1  result consumer ready
res_data  out  WIDTH  sampled acc_s
res_cout  out  1  sampled acc_cout
op_count  out  CNT_W  number of results handed off, wraps modulo 2^CNT_W
busy  out  1  FSM not in IDLE, or FIFO not empty

Behaviour:
- Reset (async, rst=1): FIFO empty, FSM=IDLE, acc_a=0, acc_sel0=0, acc_sel1=0, acc_iclk=0, res_valid=0, res_data=0, res_cout=0, op_count=0. Reset mid-operation aborts it; acc_iclk drops to 0 immediately. No partial result is issued.
- FIFO: cmd_ready = !full. Push on cmd_valid && cmd_ready. Pop only in IDLE when not empty. A push and a pop in the same cycle are both honoured, and the count is unchanged. Read/write pointers wrap modulo DEPTH. A command arriving while the FIFO is empty is still pushed first. There is no bypass, so minimum command-to-strobe latency is 3 cycles.
- FSM states: IDLE, SETUP, STROBE, HOLD, RESULT.
- IDLE: if the FIFO is non-empty, pop, register acc_a<=data and {acc_sel1,acc_sel0}<=op, then go to SETUP. Otherwise stay.
- SETUP (1 cycle): operand and selects are stable. acc_iclk=0. Go to STROBE.
- STROBE (1 cycle): acc_iclk=1. Go to HOLD.
- HOLD (1 cycle): acc_iclk=0. At the end of the cycle, sample res_data<=acc_s and res_cout<=acc_cout, set res_valid<=1, and go to RESULT.
- RESULT: res_valid=1 and res_data/res_cout are held stable until res_ready. On res_valid && res_ready: clear res_valid, op_count<=op_count+1 (wraps), go to IDLE.
- res_ready high on the first RESULT cycle completes the handshake in that cycle.
- Timing from a pop at IDLE edge t: acc_a/sel valid from t+1, acc_iclk high during cycle t+2, sample at the end of t+3, res_valid from t+4.
- Peak throughput: one operation per 5 cycles.
- acc_a and the selects hold their last values between operations and do not return to zero.
- acc_iclk is exactly one clk period wide per command. It is never asserted outside STROBE.
- Backpressure: while in RESULT with res_ready=0, the FIFO keeps accepting commands until full. Nothing is dropped.
- busy = (state!=IDLE) || !empty.

Test Plan:
- Reset then idle: hold rst=1 for 3 cycles, then release with no commands. Required: all outputs 0, cmd_ready=1, busy=0, and acc_iclk never rises over 20 cycles.
- Single op: push op=2'b01, data=4'hA with res_ready=1, using a stub that drives acc_s=4'h7, acc_cout=1. Required:
  - acc_a=4'hA, acc_sel0=1, acc_sel1=0 from 1 cycle after the pop.
  - acc_iclk high for exactly one cycle, 2 cycles after the pop.
  - res_valid for 1 cycle with res_data=4'h7, res_cout=1.
  - op_count=1.
- Fill/backpressure: res_ready=0, push 5 commands (4'h1..4'h5) back-to-back. Required:
  - 1st is popped, then the remaining 4 fill the FIFO and cmd_ready=0.
  - Commands continue to be accepted until full; none are lost.
  - Raising res_ready then yields 5 results in order 1..5 at 5-cycle spacing.
- Handshake stall: hold res_ready=0 for 10 cycles in RESULT while the stub changes acc_s. Required: res_valid stays 1, res_data keeps its sampled value, and op_count is unchanged until res_ready=1.
- Async reset mid-op: assert rst during STROBE. Required:
  - acc_iclk=0 and the FIFO empties within the same cycle, without waiting for a clock edge.
  - No res_valid pulse follows.
  - Operations resume correctly after release.
- Counter wrap: with CNT_W=8, complete 256 operations. Required: op_count returns to 0, and the 257th completion gives op_count=1.
